frame_sequencer: RTL

- Central timebase and length-clock scheduler for the sound unit.
- Divides the 4.194304 MHz system clock to a 512 Hz frame step and walks the fixed 8-step schedule.
- Emits single-cycle strobes for the length counters (256 Hz), frequency sweep (128 Hz) and volume envelope (64 Hz).
- Gates the length strobe per channel against each channel's length-enable and trigger, so each length counter receives a clean, already-qualified clock enable.

---
 rtl/frame_sequencer_pkg.sv | 22 ++
 rtl/frame_sequencer_if.sv | 23 ++
 rtl/frame_sequencer_prescaler.sv | 39 +++
 rtl/frame_sequencer.sv | 92 +++++++++
 4 files changed

// File: rtl/frame_sequencer_pkg.sv
// Shared sound-unit timebase constants: step width, reset step, per-step schedule masks
// and default sizing for frame_sequencer.
package apu_pkg;

  localparam int unsigned FS_STEP_W    = 3;
  typedef logic [FS_STEP_W-1:0] fs_step_t;

  localparam fs_step_t    STEP_RESET   = 3'd7;

  // bit n set = strobe fires when step n is entered
  localparam logic [7:0]  LEN_STEPS    = 8'b0101_0101;
  localparam logic [7:0]  SWEEP_STEPS  = 8'b0100_0100;
  localparam logic [7:0]  ENV_STEPS    = 8'b1000_0000;

  localparam int unsigned DEF_NUM_CH   = 4;
  localparam int unsigned DEF_PRESCALE = 8192;

  function automatic logic sched_hit(input logic [7:0] mask, input fs_step_t s);
    return mask[s];
  endfunction

endpackage

// File: rtl/frame_sequencer_if.sv
// Control/strobe bundle between the sound-unit core and frame_sequencer.
interface frame_sequencer_if #(
  parameter int unsigned NUM_CH = 4
);
  logic              apu_en;
  logic [NUM_CH-1:0] len_en;
  logic [NUM_CH-1:0] trigger;
  logic [2:0]        step;
  logic              len_tick;
  logic              sweep_tick;
  logic              env_tick;
  logic [NUM_CH-1:0] len_clk;

  modport master (
    output apu_en, len_en, trigger,
    input  step, len_tick, sweep_tick, env_tick, len_clk
  );

  modport slave (
    input  apu_en, len_en, trigger,
    output step, len_tick, sweep_tick, env_tick, len_clk
  );
endinterface

// File: rtl/frame_sequencer_prescaler.sv
// fs_prescaler: divides the system clock down to the frame-step advance pulse.
module fs_prescaler
  import apu_pkg::*;
#(
  parameter int unsigned PRESCALE = DEF_PRESCALE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic adv
);

  localparam int unsigned CNT_W = $clog2(PRESCALE);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] pre_cnt_q, pre_cnt_d;

  always_comb begin
    pre_cnt_d = pre_cnt_q;
    adv       = 1'b0;
    if (clr) begin
      pre_cnt_d = '0;
    end else if (en) begin
      if (pre_cnt_q == LAST) begin
        pre_cnt_d = '0;
        adv       = 1'b1;
      end else begin
        pre_cnt_d = pre_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pre_cnt_q <= '0;
    else        pre_cnt_q <= pre_cnt_d;
  end

endmodule

// File: rtl/frame_sequencer.sv
// 512 Hz frame sequencer: 8-step schedule, length/sweep/envelope strobes, qualified
// per-channel length clocks. LEN_EXTRA_CLOCK_EN adds the extra length clock on len_en rise.
module frame_sequencer
  import apu_pkg::*;
#(
  parameter int unsigned PRESCALE = DEF_PRESCALE,
  parameter int unsigned NUM_CH   = DEF_NUM_CH
) (
  input  logic             clk,
  input  logic             rst_n,
  frame_sequencer_if.slave bus
);

  logic              adv;
  fs_step_t          step_q, step_d;
  logic              len_tick_q, len_tick_d;
  logic              sweep_tick_q, sweep_tick_d;
  logic              env_tick_q, env_tick_d;
  logic [NUM_CH-1:0] len_clk_q, len_clk_d;
`ifdef LEN_EXTRA_CLOCK_EN
  logic [NUM_CH-1:0] len_en_q, len_en_d;
`endif

  fs_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (!bus.apu_en),
    .en    (bus.apu_en),
    .adv   (adv)
  );

  always_comb begin
    step_d       = step_q;
    len_tick_d   = 1'b0;
    sweep_tick_d = 1'b0;
    env_tick_d   = 1'b0;
    len_clk_d    = '0;
`ifdef LEN_EXTRA_CLOCK_EN
    len_en_d     = len_en_q;
`endif
    if (!bus.apu_en) begin
      step_d = STEP_RESET;
`ifdef LEN_EXTRA_CLOCK_EN
      len_en_d = '0;
`endif
    end else begin
      if (adv) begin
        step_d       = step_q + 1'b1;
        len_tick_d   = sched_hit(LEN_STEPS, step_d);
        sweep_tick_d = sched_hit(SWEEP_STEPS, step_d);
        env_tick_d   = sched_hit(ENV_STEPS, step_d);
        len_clk_d    = {NUM_CH{len_tick_d}} & bus.len_en & ~bus.trigger;
      end
`ifdef LEN_EXTRA_CLOCK_EN
      // Enabling length while the upcoming step will not clock it costs one extra clock.
      len_clk_d = len_clk_d |
                  (bus.len_en & ~len_en_q & ~bus.trigger & {NUM_CH{~step_q[0]}});
      len_en_d  = bus.len_en;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q       <= STEP_RESET;
      len_tick_q   <= 1'b0;
      sweep_tick_q <= 1'b0;
      env_tick_q   <= 1'b0;
      len_clk_q    <= '0;
    end else begin
      step_q       <= step_d;
      len_tick_q   <= len_tick_d;
      sweep_tick_q <= sweep_tick_d;
      env_tick_q   <= env_tick_d;
      len_clk_q    <= len_clk_d;
    end
  end

`ifdef LEN_EXTRA_CLOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) len_en_q <= '0;
    else        len_en_q <= len_en_d;
  end
`endif

  assign bus.step       = step_q;
  assign bus.len_tick   = len_tick_q;
  assign bus.sweep_tick = sweep_tick_q;
  assign bus.env_tick   = env_tick_q;
  assign bus.len_clk    = len_clk_q;

endmodule
